// File: rtl/sv39_ptw_if.sv
// Handshake bundles for the Sv39 page-table walker.
// sv39_req_if carries the translation request/response exchanged with the mmu switch.
// sv39_tl_if carries the TileLink A/D channels the walker uses to fetch PTEs.

interface sv39_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_vaddr;
    logic [1:0]  req_acc;
    logic        resp_valid;
    logic [63:0] resp_paddr;
    logic        resp_fault;

    // The requester (mmu side)
    modport master (
        output req_valid, req_vaddr, req_acc,
        input  req_ready, resp_valid, resp_paddr, resp_fault
    );

    // The walker
    modport slave (
        input  req_valid, req_vaddr, req_acc,
        output req_ready, resp_valid, resp_paddr, resp_fault
    );
endinterface

interface sv39_tl_if;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [63:0] d_data;
    logic        d_denied;
    logic        d_valid;
    logic        d_ready;

    // The walker issuing Gets
    modport master (
        output a_opcode, a_size, a_source, a_address, a_mask, a_valid, d_ready,
        input  a_ready, d_opcode, d_data, d_denied, d_valid
    );

    // The memory answering them
    modport slave (
        input  a_opcode, a_size, a_source, a_address, a_mask, a_valid, d_ready,
        output a_ready, d_opcode, d_data, d_denied, d_valid
    );
endinterface

// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker: one walk and one bus beat in flight at a time.
// Translates a virtual address through up to three PTE reads (TileLink Get) and
// returns a physical address or a page fault. A/D bits are never updated; a
// clear A (or clear D on a store) faults.
// Optional feature macro: PTW_CACHE_EN adds a one-entry leaf translation cache.
// Parameter SOURCE_ID sets a_source on every Get.

module sv39_ptw #(
    parameter logic [3:0] SOURCE_ID = 4'h2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] satp_i,
    input  logic        sfence_i,
    sv39_req_if.slave   req,
    sv39_tl_if.master   tl
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] vaddr_q, vaddr_d;
    logic [1:0]  acc_q, acc_d;
    logic [1:0]  level_q, level_d;
    logic [55:0] tableBase_q, tableBase_d;
    logic        modeSv39_q, modeSv39_d;
    logic [63:0] resultPaddr_q, resultPaddr_d;
    logic        resultFault_q, resultFault_d;

    logic [8:0]  vpnSel;
    logic [9:0]  pteFlags;
    logic [43:0] ptePpn;
    logic        canonical;

    // Leaf check shared by walks and cache hits: permission, accessed/dirty, superpage alignment.
    function automatic logic leafFault(input logic r, input logic w, input logic x,
                                       input logic a, input logic d, input logic [1:0] acc,
                                       input logic [1:0] lvl, input logic [43:0] ppn);
        logic permOk;
        logic misaligned;
        case (acc)
            2'd0:    permOk = x;
            2'd2:    permOk = w & d;
            default: permOk = r;
        endcase
        misaligned = ((lvl == 2'd2) && (ppn[17:0] != 18'h0)) ||
                     ((lvl == 2'd1) && (ppn[8:0] != 9'h0));
        return !permOk || !a || misaligned;
    endfunction

    // Physical address of a leaf: PPN with the VPN bits below the leaf level taken from the vaddr.
    function automatic logic [55:0] leafPaddr(input logic [43:0] ppn, input logic [1:0] lvl,
                                              input logic [63:0] va);
        logic [55:0] pa;
        case (lvl)
            2'd2:    pa = {ppn[43:18], va[29:0]};
            2'd1:    pa = {ppn[43:9], va[20:0]};
            default: pa = {ppn, va[11:0]};
        endcase
        return pa;
    endfunction

    // Select the VPN slice indexing the table at the current level.
    always_comb begin
        case (level_q)
            2'd2:    vpnSel = vaddr_q[38:30];
            2'd1:    vpnSel = vaddr_q[29:21];
            default: vpnSel = vaddr_q[20:12];
        endcase
    end

    assign pteFlags  = tl.d_data[9:0];
    assign ptePpn    = tl.d_data[53:10];
    assign canonical = (vaddr_q[63:39] == {25{vaddr_q[38]}});

`ifdef PTW_CACHE_EN
    logic        cacheValid_q;
    logic [26:0] cacheVpn_q;
    logic [1:0]  cacheLvl_q;
    logic [9:0]  cachePte_q;
    logic [43:0] cachePpn_q;
    logic [63:0] satpSeen_q;
    logic        cacheHit;
    logic        cacheHitFault;
    logic        cacheFill;

    // Tag compare against the cached leaf: only VPN bits above the cached level matter.
    always_comb begin
        cacheHit = 1'b0;
        if (cacheValid_q) begin
            case (cacheLvl_q)
                2'd2:    cacheHit = (vaddr_q[38:30] == cacheVpn_q[26:18]);
                2'd1:    cacheHit = (vaddr_q[38:21] == cacheVpn_q[26:9]);
                default: cacheHit = (vaddr_q[38:12] == cacheVpn_q);
            endcase
        end
        cacheHitFault = leafFault(cachePte_q[1], cachePte_q[2], cachePte_q[3], cachePte_q[6],
                                  cachePte_q[7], acc_q, cacheLvl_q, cachePpn_q);
    end

    // Fill on every good leaf; drop the entry on sfence or whenever satp changes value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cacheValid_q <= 1'b0;
            satpSeen_q   <= 64'h0;
        end else begin
            satpSeen_q <= satp_i;
            if (sfence_i || (satp_i != satpSeen_q)) begin
                cacheValid_q <= 1'b0;
            end else if (cacheFill) begin
                cacheValid_q <= 1'b1;
                cacheVpn_q   <= vaddr_q[38:12];
                cacheLvl_q   <= level_q;
                cachePte_q   <= pteFlags;
                cachePpn_q   <= ptePpn;
            end
        end
    end

    logic unusedBits;
    assign unusedBits = ^{tl.d_data[63:54], cachePte_q[9:8], cachePte_q[5:4], cachePte_q[0]};
`else
    logic unusedBits;
    assign unusedBits = ^{tl.d_data[63:54], tl.d_data[9:8], tl.d_data[5:4], satp_i[59:44], sfence_i};
`endif

    // Walk sequencing: latch request, screen it, then read PTEs level by level until a leaf or fault.
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        acc_d         = acc_q;
        level_d       = level_q;
        tableBase_d   = tableBase_q;
        modeSv39_d    = modeSv39_q;
        resultPaddr_d = resultPaddr_q;
        resultFault_d = resultFault_q;
`ifdef PTW_CACHE_EN
        cacheFill     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    vaddr_d     = req.req_vaddr;
                    acc_d       = req.req_acc;
                    level_d     = 2'd2;
                    tableBase_d = {satp_i[43:0], 12'h0};
                    modeSv39_d  = (satp_i[63:60] == 4'd8);
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (!modeSv39_q) begin
                    resultPaddr_d = vaddr_q;
                    resultFault_d = 1'b0;
                end else if (!canonical) begin
                    resultPaddr_d = 64'h0;
                    resultFault_d = 1'b1;
`ifdef PTW_CACHE_EN
                end else if (cacheHit) begin
                    resultFault_d = cacheHitFault;
                    resultPaddr_d = cacheHitFault ? 64'h0
                                  : {8'h0, leafPaddr(cachePpn_q, cacheLvl_q, vaddr_q)};
`endif
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tl.a_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tl.d_valid) begin
                    if (tl.d_denied || (tl.d_opcode != 3'd1) || !pteFlags[0] ||
                        (!pteFlags[1] && pteFlags[2])) begin
                        resultPaddr_d = 64'h0;
                        resultFault_d = 1'b1;
                        state_d       = DONE;
                    end else if (!pteFlags[1] && !pteFlags[3]) begin
                        if (level_q == 2'd0) begin
                            resultPaddr_d = 64'h0;
                            resultFault_d = 1'b1;
                            state_d       = DONE;
                        end else begin
                            tableBase_d = {ptePpn, 12'h0};
                            level_d     = level_q - 2'd1;
                            state_d     = REQ;
                        end
                    end else begin
                        state_d = DONE;
                        if (leafFault(pteFlags[1], pteFlags[2], pteFlags[3], pteFlags[6],
                                      pteFlags[7], acc_q, level_q, ptePpn)) begin
                            resultPaddr_d = 64'h0;
                            resultFault_d = 1'b1;
                        end else begin
                            resultPaddr_d = {8'h0, leafPaddr(ptePpn, level_q, vaddr_q)};
                            resultFault_d = 1'b0;
`ifdef PTW_CACHE_EN
                            cacheFill     = 1'b1;
`endif
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and walk context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vaddr_q       <= 64'h0;
            acc_q         <= 2'd0;
            level_q       <= 2'd2;
            tableBase_q   <= 56'h0;
            modeSv39_q    <= 1'b0;
            resultPaddr_q <= 64'h0;
            resultFault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            acc_q         <= acc_d;
            level_q       <= level_d;
            tableBase_q   <= tableBase_d;
            modeSv39_q    <= modeSv39_d;
            resultPaddr_q <= resultPaddr_d;
            resultFault_q <= resultFault_d;
        end
    end

    assign req.req_ready  = (state_q == IDLE);
    assign req.resp_valid = (state_q == DONE);
    assign req.resp_paddr = (state_q == DONE) ? resultPaddr_q : 64'h0;
    assign req.resp_fault = (state_q == DONE) && resultFault_q;

    assign tl.a_valid   = (state_q == REQ);
    assign tl.a_opcode  = 3'd4;
    assign tl.a_size    = 3'd3;
    assign tl.a_source  = SOURCE_ID;
    assign tl.a_mask    = 8'hFF;
    assign tl.a_address = {8'h0, tableBase_q + {44'h0, vpnSel, 3'b000}};
    assign tl.d_ready   = 1'b1;

endmodule

// File: tb/tb_sv39_ptw.sv
// Self-checking bench for sv39_ptw: directed walks from the page-table scenarios,
// reset-in-flight cases, then randomized tables checked against a behavioural
// walker model. Honors PTW_CACHE_EN when the design is built with it.

module tb_sv39_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] satp;
    logic        sfence;

    sv39_req_if reqIf ();
    sv39_tl_if  tlIf ();

    sv39_ptw #(.SOURCE_ID(4'h2)) dut (
        .clk      (clk),
        .rst      (rst),
        .satp_i   (satp),
        .sfence_i (sfence),
        .req      (reqIf.slave),
        .tl       (tlIf.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [63:0] paddr;
        int          gets;
        int          latency;
    } result_t;

    localparam logic [63:0] ROOT = 64'h8000_0000;
    localparam logic [63:0] LEAF_FLAGS = 64'hCF;

    int checks = 0;
    int failures = 0;

    // Memory image and per-address error injection (1 = denied, 2 = bad opcode)
    logic [63:0] mem [logic [63:0]];
    int          errKind [logic [63:0]];

    // Controls owned by the stimulus process
    bit memRespond = 1'b1;
    bit holdOff = 1'b0;
    bit stallMode = 1'b0;
    int staleReq = 0;

    // State owned by the memory responder
    bit          beatPending = 1'b0;
    logic [63:0] pendingAddr;
    int          getCount = 0;
    int          staleDone = 0;
    logic [63:0] lastAddr;
    logic [2:0]  lastOpcode;
    logic [2:0]  lastSize;
    logic [7:0]  lastMask;
    logic [3:0]  lastSource;

    // Observations of the last translation
    logic [63:0] obsPaddr;
    logic        obsFault;
    int          obsLatency;
    int          obsGets;
    logic        obsPulseAfter;
    logic        timedOut;

    // Behavioural model of the one-entry leaf cache
    bit          mCacheValid = 1'b0;
    logic [63:0] mCacheVa;
    int          mCacheLvl;
    logic [63:0] mCachePte;

    function automatic logic [63:0] memRead(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // Memory: accepts Gets (with optional random stalls) and answers the cycle after acceptance
    always @(negedge clk) begin
        tlIf.d_valid  = 1'b0;
        tlIf.d_denied = 1'b0;
        tlIf.d_opcode = 3'd1;
        tlIf.d_data   = 64'h0;
        if (beatPending) begin
            tlIf.d_valid = 1'b1;
            tlIf.d_data  = memRead(pendingAddr);
            if (errKind.exists(pendingAddr)) begin
                if (errKind[pendingAddr] == 1) tlIf.d_denied = 1'b1;
                else tlIf.d_opcode = 3'd0;
            end
            beatPending = 1'b0;
        end else if (staleReq != staleDone) begin
            tlIf.d_valid = 1'b1;
            tlIf.d_data  = 64'h0000_0000_2004_8CFF;
            staleDone++;
        end
        tlIf.a_ready = holdOff ? 1'b0 : (stallMode ? 1'($urandom_range(0, 1)) : 1'b1);
        if (tlIf.a_valid === 1'b1 && tlIf.a_ready) begin
            getCount++;
            lastAddr   = tlIf.a_address;
            lastOpcode = tlIf.a_opcode;
            lastSize   = tlIf.a_size;
            lastMask   = tlIf.a_mask;
            lastSource = tlIf.a_source;
            if (memRespond) begin
                beatPending = 1'b1;
                pendingAddr = tlIf.a_address;
            end
        end
    end

    // Evaluate a leaf PTE found at level lvl using page-size arithmetic
    function automatic result_t leafEval(input logic [63:0] pte, input int lvl,
                                         input logic [63:0] va, input logic [1:0] acc);
        result_t     r;
        logic [63:0] ppn;
        logic [63:0] pageMask;
        bit          allowed;
        ppn      = (pte >> 10) & ((64'h1 << 44) - 1);
        pageMask = (64'h1 << (12 + 9 * lvl)) - 1;
        case (acc)
            2'd0:    allowed = pte[3];
            2'd2:    allowed = pte[2] && pte[7];
            default: allowed = pte[1];
        endcase
        r.gets    = 0;
        r.latency = 0;
        r.fault   = !allowed || !pte[6] || ((ppn % (64'h1 << (9 * lvl))) != 0);
        r.paddr   = r.fault ? 64'h0 : (((ppn * 4096) & ~pageMask) | (va & pageMask));
        return r;
    endfunction

    // Reference translation following the Sv39 rules directly over the memory image
    function automatic result_t modelTranslate(input logic [63:0] va, input logic [1:0] acc);
        result_t     r;
        result_t     leaf;
        logic [63:0] tbl;
        logic [63:0] addr;
        logic [63:0] pte;
        logic [63:0] top;
        r.fault = 1'b0; r.paddr = 64'h0; r.gets = 0; r.latency = 2;
        if (satp[63:60] != 4'd8) begin
            r.paddr = va;
            return r;
        end
        top = va >> 38;
        if (top != 64'h0 && top != 64'h3FF_FFFF) begin
            r.fault = 1'b1;
            return r;
        end
`ifdef PTW_CACHE_EN
        if (mCacheValid && ((va >> (12 + 9 * mCacheLvl)) % (64'h1 << (27 - 9 * mCacheLvl))) ==
                           ((mCacheVa >> (12 + 9 * mCacheLvl)) % (64'h1 << (27 - 9 * mCacheLvl)))) begin
            leaf = leafEval(mCachePte, mCacheLvl, va, acc);
            r.fault = leaf.fault;
            r.paddr = leaf.paddr;
            return r;
        end
`endif
        tbl = satp[43:0] * 4096;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            addr = tbl + ((va >> (12 + 9 * lvl)) % 512) * 8;
            r.gets++;
            r.latency += 2;
            pte = memRead(addr);
            if (errKind.exists(addr) || !pte[0] || (!pte[1] && pte[2])) begin
                r.fault = 1'b1;
                return r;
            end
            if (pte[1] || pte[3]) begin
                leaf = leafEval(pte, lvl, va, acc);
                r.fault = leaf.fault;
                r.paddr = leaf.paddr;
                if (!leaf.fault) begin
                    mCacheValid = 1'b1;
                    mCacheVa    = va;
                    mCacheLvl   = lvl;
                    mCachePte   = pte;
                end
                return r;
            end
            tbl = ((pte >> 10) % (64'h1 << 44)) * 4096;
        end
        r.fault = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one translation and collect result, latency, bus Gets and pulse width
    task automatic applyStimulus(input logic [63:0] va, input logic [1:0] acc);
        int cyc;
        int getsBefore;
        timedOut = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (reqIf.req_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        getsBefore = getCount;
        reqIf.req_valid = 1'b1;
        reqIf.req_vaddr = va;
        reqIf.req_acc   = acc;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
        cyc = 1;
        while (reqIf.resp_valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        timedOut   = (reqIf.resp_valid !== 1'b1);
        obsLatency = cyc;
        obsPaddr   = reqIf.resp_paddr;
        obsFault   = reqIf.resp_fault;
        @(negedge clk);
        obsPulseAfter = reqIf.resp_valid;
        obsGets       = getCount - getsBefore;
    endtask

    task automatic runCase(input string tag, input logic [63:0] va, input logic [1:0] acc,
                           input bit checkLat);
        result_t exp;
        exp = modelTranslate(va, acc);
        applyStimulus(va, acc);
        checkOutput({tag, "_timeout"}, 64'(timedOut), 64'h0);
        checkOutput({tag, "_fault"}, 64'(obsFault), 64'(exp.fault));
        checkOutput({tag, "_paddr"}, obsPaddr, exp.paddr);
        checkOutput({tag, "_gets"}, 64'(obsGets), 64'(exp.gets));
        checkOutput({tag, "_pulse"}, 64'(obsPulseAfter), 64'h0);
        if (checkLat) checkOutput({tag, "_latency"}, 64'(obsLatency), 64'(exp.latency));
    endtask

    task automatic writePte(input logic [63:0] addr, input logic [63:0] val);
        mem[addr] = val;
        if (errKind.exists(addr)) errKind.delete(addr);
    endtask

    task automatic doSfence();
        @(negedge clk);
        sfence = 1'b1;
        @(negedge clk);
        sfence = 1'b0;
        mCacheValid = 1'b0;
    endtask

    task automatic setSatp(input logic [63:0] v);
        @(negedge clk);
        if (v != satp) mCacheValid = 1'b0;
        satp = v;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] va;
        logic [63:0] addrA;
        logic [63:0] leafPte;
        logic [63:0] ppn;
        int          cyc;
        int          pulses;
        int          leafLvl;
        logic [63:0] t1;
        logic [63:0] t0;

        rst    = 1'b1;
        sfence = 1'b0;
        satp   = (64'h8 << 60) | 64'h80000;
        reqIf.req_valid = 1'b0;
        reqIf.req_vaddr = 64'h0;
        reqIf.req_acc   = 2'd0;
        repeat (3) @(negedge clk);

        checkOutput("rst_req_ready", 64'(reqIf.req_ready), 64'h1);
        checkOutput("rst_a_valid", 64'(tlIf.a_valid), 64'h0);
        checkOutput("rst_resp_valid", 64'(reqIf.resp_valid), 64'h0);
        checkOutput("rst_resp_fault", 64'(reqIf.resp_fault), 64'h0);
        checkOutput("rst_resp_paddr", reqIf.resp_paddr, 64'h0);
        rst = 1'b0;
        mCacheValid = 1'b0;

        // Three-level walk to a 4K leaf
        writePte(ROOT, (64'h80001 << 10) | 64'h1);
        writePte(64'h8000_1000, (64'h80002 << 10) | 64'h1);
        writePte(64'h8000_2008, (64'h80123 << 10) | LEAF_FLAGS);
        runCase("walk4k", 64'h1234, 2'd1, 1'b1);
        checkOutput("walk4k_paddr_value", obsPaddr, 64'h8012_3234);
        checkOutput("a_opcode", 64'(lastOpcode), 64'd4);
        checkOutput("a_size", 64'(lastSize), 64'd3);
        checkOutput("a_mask", 64'(lastMask), 64'hFF);
        checkOutput("a_source", 64'(lastSource), 64'h2);
        checkOutput("a_last_address", lastAddr, 64'h8000_2008);

        // Aligned 2M superpage at level 1
        writePte(64'h8000_1008, (64'h80200 << 10) | LEAF_FLAGS);
        runCase("super2m", 64'h0034_5678, 2'd1, 1'b1);
        checkOutput("super2m_paddr_value", obsPaddr, 64'h8034_5678);

        // Misaligned superpage
        writePte(64'h8000_1008, (64'h80201 << 10) | LEAF_FLAGS);
        doSfence();
        runCase("misalign", 64'h0034_5678, 2'd1, 1'b1);

        // Invalid leaf
        writePte(64'h8000_2008, (64'h80123 << 10) | 64'hCE);
        doSfence();
        runCase("leaf_invalid", 64'h1234, 2'd1, 1'b1);

        // Clean page: store faults, load succeeds
        writePte(64'h8000_2008, (64'h80123 << 10) | 64'h4F);
        doSfence();
        runCase("store_dirty0", 64'h1234, 2'd2, 1'b1);
        runCase("load_dirty0", 64'h1234, 2'd1, 1'b1);
        runCase("fetch_dirty0", 64'h1234, 2'd0, 1'b1);

        // Non-canonical and bypass
        runCase("noncanon", 64'h0000_0040_0000_0000, 2'd1, 1'b1);
        setSatp(64'h0);
        runCase("bypass", 64'hDEAD, 2'd1, 1'b1);
        checkOutput("bypass_paddr_value", obsPaddr, 64'hDEAD);
        setSatp((64'h8 << 60) | 64'h80000);

        // Repeat load: cached builds answer without bus traffic until sfence
        writePte(64'h8000_2008, (64'h80123 << 10) | LEAF_FLAGS);
        doSfence();
        runCase("cache_fill", 64'h1234, 2'd1, 1'b1);
        runCase("cache_repeat", 64'h1234, 2'd1, 1'b1);
`ifdef PTW_CACHE_EN
        checkOutput("cache_repeat_zero_gets", 64'(obsGets), 64'h0);
`endif
        doSfence();
        runCase("after_sfence", 64'h1234, 2'd1, 1'b1);

        // Reset while a Get waits for acceptance: address holds, then a_valid drops
        holdOff = 1'b1;
        @(negedge clk);
        reqIf.req_valid = 1'b1;
        reqIf.req_vaddr = 64'h0034_5000;
        reqIf.req_acc   = 2'd1;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
        cyc = 0;
        while (tlIf.a_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_a_valid", 64'(tlIf.a_valid), 64'h1);
        addrA = tlIf.a_address;
        @(negedge clk);
        checkOutput("stall_addr_stable", tlIf.a_address, addrA);
        checkOutput("stall_a_valid_held", 64'(tlIf.a_valid), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mCacheValid = 1'b0;
        checkOutput("rst_req_a_valid", 64'(tlIf.a_valid), 64'h0);
        checkOutput("rst_req_ready", 64'(reqIf.req_ready), 64'h1);
        holdOff = 1'b0;

        // Reset while waiting for the data beat; the late beat must be discarded
        memRespond = 1'b0;
        @(negedge clk);
        reqIf.req_valid = 1'b1;
        reqIf.req_vaddr = 64'h1234;
        reqIf.req_acc   = 2'd1;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
        cyc = 0;
        while (tlIf.a_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mCacheValid = 1'b0;
        memRespond  = 1'b1;
        checkOutput("rst_wait_a_valid", 64'(tlIf.a_valid), 64'h0);
        checkOutput("rst_wait_ready", 64'(reqIf.req_ready), 64'h1);
        staleReq++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (reqIf.resp_valid === 1'b1) pulses++;
        end
        checkOutput("rst_no_resp_pulse", 64'(pulses), 64'h0);
        checkOutput("stale_idle_ready", 64'(reqIf.req_ready), 64'h1);
        runCase("post_reset_walk", 64'h1234, 2'd1, 1'b1);

        // Randomized tables, access types, errors and bus stalls
        for (int it = 0; it < 40; it++) begin
            stallMode = (it >= 20);
            va = {$urandom, $urandom};
            va = {{25{va[38]}}, va[38:0]};
            if ($urandom_range(0, 7) == 0) va[50] = ~va[50];
            leafLvl = $urandom_range(0, 2);
            t1 = 64'h90000 + 64'(2 * it);
            t0 = t1 + 1;
            ppn = 64'($urandom);
            if ($urandom_range(0, 3) != 0) ppn = ppn & ~((64'h1 << (9 * leafLvl)) - 1);
            leafPte = (ppn << 10) | 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) leafPte = leafPte | 64'hC1;
            addrA = ROOT + ((va >> 30) % 512) * 8;
            writePte(addrA, (leafLvl == 2) ? leafPte : ((t1 << 10) | 64'h1));
            if ($urandom_range(0, 9) == 0) errKind[addrA] = $urandom_range(1, 2);
            if (leafLvl < 2) writePte(t1 * 4096 + ((va >> 21) % 512) * 8,
                                      (leafLvl == 1) ? leafPte : ((t0 << 10) | 64'h1));
            if (leafLvl == 0) writePte(t0 * 4096 + ((va >> 12) % 512) * 8, leafPte);
            if ($urandom_range(0, 3) == 0) doSfence();
            runCase($sformatf("rand%0d", it), va, 2'($urandom_range(0, 3)), !stallMode);
        end
        stallMode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
